mmio_console: RTL and testbench

Memory-mapped console and simulation-exit peripheral on the core's data port, alongside `data_mem`. It decodes a small register window at `BASE_ADDR`. Byte writes to TXDATA go into a FIFO that drains over a valid/ready character stream with programmable inter-character spacing. A write to EXIT raises a sticky `halt` with an exit code, so the testbench ends the run on `halt` instead of waiting a fixed cycle count.

---
 rtl/mmio_console.sv | 153 +++++++++++++++
 tb/tb_mmio_console.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_console.sv
// Memory-mapped console and simulation-exit peripheral: TX FIFO drained over valid/ready, sticky halt.
// Optional MMIO_CONSOLE_DISPLAY_EN echoes characters and the exit code from simulation.
module mmio_console #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wmask,
  input  logic        data_wen,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] exit_code
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          halt_q, halt_d;
  logic [31:0]   exit_code_q, exit_code_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic [1:0] offset;
  logic       wr_en, push_req, push_ok, pop, full, empty, exit_wr;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^data_addr[1:0];

  assign offset   = data_addr[3:2];
  assign sel      = (data_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_en    = data_wen && sel;
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = (state_q == SEND) && tx_ready;
  assign push_req = wr_en && (offset == 2'd0) && data_wmask[0];
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok  = push_req && (!full || pop);
  assign exit_wr  = wr_en && (offset == 2'd2) && (data_wmask != 4'b0000);

  assign tx_valid  = (state_q == SEND);
  assign tx_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign halt      = halt_q;
  assign exit_code = exit_code_q;

  always_comb begin
    wr_ptr_d    = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    if (push_ok && !pop)
      count_d = count_q + 1'b1;
    else if (!push_ok && pop)
      count_d = count_q - 1'b1;
    overflow_d  = overflow_q | (push_req && full && !pop);
    halt_d      = halt_q;
    exit_code_d = exit_code_q;
    if (exit_wr && !halt_q) begin
      halt_d      = 1'b1;
      exit_code_d = data_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: if (!empty) state_d = SEND;
      SEND: begin
        if (tx_ready) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d   = GAP;
            gap_cnt_d = GW'(1);
          end
        end
      end
      GAP: begin
        if (gap_cnt_q >= GW'(GAP_CYCLES))
          state_d = IDLE;
        else
          gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gap_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      halt_q      <= 1'b0;
      exit_code_q <= '0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      halt_q      <= halt_d;
      exit_code_q <= exit_code_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= data_wdata[7:0];
  end

  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      case (offset)
        2'd1:    rdata = {16'h0, 8'(count_q), 5'h0, overflow_q, empty, full};
        2'd2:    rdata = exit_code_q;
        default: rdata = 32'h0;
      endcase
    end
  end

`ifdef MMIO_CONSOLE_DISPLAY_EN
  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready)
      $write("%c", tx_data);
    if (rst_n && halt_d && !halt_q)
      $display("EXIT code=%0d", exit_code_d);
  end
`else
  // Synthesis builds carry no simulation output.
`endif

endmodule

// File: tb/tb_mmio_console.sv
// Directed self-checking bench for mmio_console with default parameters (depth 8, gap 4).
module tb_mmio_console;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wmask;
  logic        data_wen;
  logic [31:0] rdata;
  logic        sel;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic [31:0] exit_code;

  int total = 0;
  int bad   = 0;

  mmio_console dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_wmask (data_wmask),
    .data_wen   (data_wen),
    .rdata      (rdata),
    .sel        (sel),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .halt       (halt),
    .exit_code  (exit_code)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; the write lands on the next rising edge and we return at the following falling edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    data_addr  = addr;
    data_wdata = data;
    data_wmask = mask;
    data_wen   = 1'b1;
    @(negedge clk);
    data_wen   = 1'b0;
    data_wmask = 4'b0000;
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] val);
    data_addr = addr;
    #1;
    val = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0; data_addr = BASE; data_wdata = 0; data_wmask = 0; data_wen = 0; tx_ready = 0;
    repeat (2) @(negedge clk);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt: got %b want 0", halt); end
    total++; if (exit_code !== 32'h0) begin bad++; $display("FAIL reset_exit_code: got %h want 0", exit_code); end
    read_reg(BASE + 4, v);
    total++; if (v !== 32'h0000_0002) begin bad++; $display("FAIL reset_status: got %h want 00000002", v); end
    total++; if (sel !== 1'b1) begin bad++; $display("FAIL sel_in_window: got %b want 1", sel); end
    read_reg(32'h1000_0014, v);
    total++; if (sel !== 1'b0 || v !== 32'h0) begin bad++; $display("FAIL sel_outside: got sel=%b rdata=%h want 0/0", sel, v); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_push();
    logic [31:0] v;
    tx_ready = 1'b1;
    do_write(BASE, 32'h41, 4'b0001);
    read_reg(BASE + 4, v);
    total++; if (v !== 32'h0000_0100) begin bad++; $display("FAIL push_status: got %h want 00000100", v); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL push_valid_early: got %b want 0", tx_valid); end
    @(negedge clk);
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin bad++; $display("FAIL push_valid: got v=%b d=%h want 1/41", tx_valid, tx_data); end
    @(negedge clk);
    read_reg(BASE + 4, v);
    total++; if (v !== 32'h0000_0002 || tx_valid !== 1'b0) begin bad++; $display("FAIL post_handshake: got status=%h v=%b want 00000002/0", v, tx_valid); end
    repeat (6) @(negedge clk);
    do_write(BASE, 32'h55, 4'b0010);
    read_reg(BASE + 4, v);
    total++; if (v !== 32'h0000_0002) begin bad++; $display("FAIL masked_push: got %h want 00000002", v); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_burst();
    logic [7:0] got[$];
    int         when[$];
    logic [31:0] v;
    logic [7:0] exp_c [3];
    exp_c[0] = 8'h41; exp_c[1] = 8'h42; exp_c[2] = 8'h43;
    tx_ready = 1'b0;
    do_write(BASE, 32'h41, 4'b0001);
    do_write(BASE, 32'h42, 4'b0001);
    do_write(BASE, 32'h43, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin bad++; $display("FAIL stall_hold[%0d]: got v=%b d=%h want 1/41", i, tx_valid, tx_data); end
      @(negedge clk);
    end
    tx_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (tx_valid && tx_ready) begin got.push_back(tx_data); when.push_back(c); end
      @(negedge clk);
    end
    total++; if (got.size() !== 3) begin bad++; $display("FAIL burst_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++; if (got[i] !== exp_c[i] || when[i] !== i * 6) begin bad++; $display("FAIL burst_char[%0d]: got %h@%0d want %h@%0d", i, got[i], when[i], exp_c[i], i * 6); end
    end
    read_reg(BASE + 4, v);
    total++; if (v !== 32'h0000_0002) begin bad++; $display("FAIL burst_status: got %h want 00000002", v); end
  endtask

  task automatic test_overflow_and_full_pop();
    logic [7:0] got[$];
    logic [31:0] v;
    logic [7:0] exp_c [8];
    for (int i = 0; i < 7; i++) exp_c[i] = 8'h51 + 8'(i);
    exp_c[7] = 8'h60;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) do_write(BASE, 32'h50 + i, 4'b0001);
    read_reg(BASE + 4, v);
    total++; if (v !== 32'h0000_0805) begin bad++; $display("FAIL overflow_status: got %h want 00000805", v); end
    @(negedge clk);
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h50) begin bad++; $display("FAIL full_head: got v=%b d=%h want 1/50", tx_valid, tx_data); end
    tx_ready = 1'b1;
    do_write(BASE, 32'h60, 4'b0001);
    tx_ready = 1'b0;
    read_reg(BASE + 4, v);
    total++; if (v !== 32'h0000_0805) begin bad++; $display("FAIL full_pop_status: got %h want 00000805", v); end
    tx_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (tx_valid && tx_ready) got.push_back(tx_data);
      @(negedge clk);
    end
    total++; if (got.size() !== 8) begin bad++; $display("FAIL drain_count: got %0d want 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      total++; if (got[i] !== exp_c[i]) begin bad++; $display("FAIL drain_char[%0d]: got %h want %h", i, got[i], exp_c[i]); end
    end
    read_reg(BASE + 4, v);
    total++; if (v !== 32'h0000_0006) begin bad++; $display("FAIL drained_status: got %h want 00000006", v); end
    tx_ready = 1'b0;
  endtask

  task automatic test_exit();
    logic [31:0] v;
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL halt_before: got %b want 0", halt); end
    do_write(BASE + 8, 32'h0000_002A, 4'b1111);
    total++; if (halt !== 1'b1 || exit_code !== 32'd42) begin bad++; $display("FAIL exit_first: got halt=%b code=%0d want 1/42", halt, exit_code); end
    do_write(BASE + 8, 32'h7, 4'b1111);
    total++; if (halt !== 1'b1 || exit_code !== 32'd42) begin bad++; $display("FAIL exit_second: got halt=%b code=%0d want 1/42", halt, exit_code); end
    read_reg(BASE + 8, v);
    total++; if (v !== 32'd42) begin bad++; $display("FAIL exit_read: got %0d want 42", v); end
    read_reg(BASE + 0, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL txdata_read: got %h want 0", v); end
    read_reg(BASE + 12, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reserved_read: got %h want 0", v); end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    logic [31:0] v;
    tx_ready = 1'b0;
    do_write(BASE, 32'h70, 4'b0001);
    @(negedge clk);
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h70) begin bad++; $display("FAIL after_halt_push: got v=%b d=%h want 1/70", tx_valid, tx_data); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL midreset_tx: got v=%b d=%h want 0/00", tx_valid, tx_data); end
    total++; if (halt !== 1'b0 || exit_code !== 32'h0) begin bad++; $display("FAIL midreset_halt: got halt=%b code=%h want 0/0", halt, exit_code); end
    read_reg(BASE + 4, v);
    total++; if (v !== 32'h0000_0002) begin bad++; $display("FAIL midreset_status: got %h want 00000002", v); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %b want 0", tx_valid); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_burst();
    test_overflow_and_full_pop();
    test_exit();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
